// File: rtl/nand_op_sequencer.sv
// Single-channel NAND operation sequencer: runs one RESET/READ/PROGRAM request at a time
// and generates the registered CLE/ALE/WEN/REN/IO bus cycles for one flash device.
module nand_op_sequencer #(
  parameter int PAGE_BYTES = 32,
  parameter int ADDR_BYTES = 4,
  parameter int TWB_CYC    = 2,
  parameter int TOUT_CYC   = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr,
  input  logic [7:0]              wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    err,
  inout  wire  [7:0]              F_IO,
  output logic                    F_CLE,
  output logic                    F_ALE,
  output logic                    F_WEN,
  output logic                    F_REN,
  input  logic                    F_RB
);

  localparam logic [1:0] OP_RESET   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_PROGRAM = 2'b10;
  localparam int         ADDR_W     = 8 * ADDR_BYTES;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD1, ST_ADDR, ST_WAIT_WB, ST_WAIT_RB,
    ST_RDATA, ST_WDATA, ST_CMD2, ST_DONE
  } state_t;

  state_t              state_r;
  logic                phase_r;
  logic [1:0]          op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [8:0]          byte_cnt_r;
  logic [15:0]         wait_cnt_r;
  logic                err_pend_r;
  logic                cle_r, ale_r, wen_r, ren_r;
  logic [7:0]          io_out_r;
  logic                io_oe_r;
  logic                cmd_ready_r, wr_ready_r, rd_valid_r, done_r, err_r;
  logic [7:0]          rd_data_r;

  function automatic logic [7:0] opcode_of(input logic [1:0] op);
    logic [7:0] code_s;
    case (op)
      OP_RESET:   code_s = 8'hFF;
      OP_READ:    code_s = 8'h00;
      OP_PROGRAM: code_s = 8'h80;
      default:    code_s = 8'h00;
    endcase
    return code_s;
  endfunction

  assign F_IO      = io_oe_r ? io_out_r : 8'hzz;
  assign F_CLE     = cle_r;
  assign F_ALE     = ale_r;
  assign F_WEN     = wen_r;
  assign F_REN     = ren_r;
  assign cmd_ready = cmd_ready_r;
  assign wr_ready  = wr_ready_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;

  // Operation FSM; phase_r=0 is the strobe-low clock of a bus cycle, phase_r=1 the strobe-high clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= 1'b0;
      op_r        <= 2'b00;
      addr_r      <= {ADDR_W{1'b0}};
      byte_cnt_r  <= 9'd0;
      wait_cnt_r  <= 16'd0;
      err_pend_r  <= 1'b0;
      cle_r       <= 1'b0;
      ale_r       <= 1'b0;
      wen_r       <= 1'b1;
      ren_r       <= 1'b1;
      io_out_r    <= 8'h00;
      io_oe_r     <= 1'b0;
      cmd_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
      rd_data_r   <= 8'h00;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            op_r        <= cmd_op;
            addr_r      <= cmd_addr;
            byte_cnt_r  <= 9'd0;
            if (cmd_op == 2'b11) begin
              err_pend_r <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              state_r  <= ST_CMD1;
              phase_r  <= 1'b0;
              cle_r    <= 1'b1;
              wen_r    <= 1'b0;
              io_oe_r  <= 1'b1;
              io_out_r <= opcode_of(cmd_op);
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_CMD1: begin
          if (!phase_r) begin
            wen_r   <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            cle_r <= 1'b0;
            if (op_r == OP_RESET) begin
              io_oe_r    <= 1'b0;
              wait_cnt_r <= 16'd0;
              state_r    <= ST_WAIT_WB;
            end else begin
              ale_r      <= 1'b1;
              wen_r      <= 1'b0;
              phase_r    <= 1'b0;
              io_out_r   <= addr_r[7:0];
              addr_r     <= addr_r >> 4'd8;
              byte_cnt_r <= 9'd0;
              state_r    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (!phase_r) begin
            wen_r   <= 1'b1;
            phase_r <= 1'b1;
          end else if (byte_cnt_r == 9'(ADDR_BYTES - 1)) begin
            ale_r      <= 1'b0;
            byte_cnt_r <= 9'd0;
            if (op_r == OP_READ) begin
              io_oe_r    <= 1'b0;
              wait_cnt_r <= 16'd0;
              state_r    <= ST_WAIT_WB;
            end else begin
              wr_ready_r <= 1'b1;
              state_r    <= ST_WDATA;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r + 9'd1;
            io_out_r   <= addr_r[7:0];
            addr_r     <= addr_r >> 4'd8;
            wen_r      <= 1'b0;
            phase_r    <= 1'b0;
          end
        end
        ST_WAIT_WB: begin
          if (wait_cnt_r == 16'(TWB_CYC - 1)) begin
            wait_cnt_r <= 16'd0;
            state_r    <= ST_WAIT_RB;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_WAIT_RB: begin
          if (F_RB) begin
            if (op_r == OP_READ) begin
              ren_r      <= 1'b0;
              phase_r    <= 1'b0;
              byte_cnt_r <= 9'd0;
              state_r    <= ST_RDATA;
            end else begin
              state_r <= ST_DONE;
            end
          end else if (wait_cnt_r == 16'(TOUT_CYC - 1)) begin
            err_pend_r <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_RDATA: begin
          // Capture on the same edge that raises REN, while the flash still drives the bus.
          if (!phase_r) begin
            ren_r      <= 1'b1;
            phase_r    <= 1'b1;
            rd_data_r  <= F_IO;
            rd_valid_r <= 1'b1;
            byte_cnt_r <= byte_cnt_r + 9'd1;
          end else if (byte_cnt_r == 9'(PAGE_BYTES)) begin
            state_r <= ST_DONE;
          end else begin
            ren_r   <= 1'b0;
            phase_r <= 1'b0;
          end
        end
        ST_WDATA: begin
          // wr_ready only in the WEN-high clock that can launch the next byte; no pulse on stall.
          if (!phase_r) begin
            wen_r      <= 1'b1;
            phase_r    <= 1'b1;
            wr_ready_r <= (byte_cnt_r != 9'(PAGE_BYTES));
          end else if (byte_cnt_r == 9'(PAGE_BYTES)) begin
            cle_r    <= 1'b1;
            io_out_r <= 8'h10;
            wen_r    <= 1'b0;
            phase_r  <= 1'b0;
            state_r  <= ST_CMD2;
          end else if (wr_valid && wr_ready_r) begin
            io_out_r   <= wr_data;
            wen_r      <= 1'b0;
            wr_ready_r <= 1'b0;
            phase_r    <= 1'b0;
            byte_cnt_r <= byte_cnt_r + 9'd1;
          end else begin
            wr_ready_r <= 1'b1;
          end
        end
        ST_CMD2: begin
          if (!phase_r) begin
            wen_r   <= 1'b1;
            phase_r <= 1'b1;
          end else begin
            cle_r      <= 1'b0;
            io_oe_r    <= 1'b0;
            wait_cnt_r <= 16'd0;
            state_r    <= ST_WAIT_WB;
          end
        end
        ST_DONE: begin
          done_r      <= 1'b1;
          err_r       <= err_pend_r;
          err_pend_r  <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
